// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states and sizing constants.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on magnitudes: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // rem < divisor_mag holds on entry, so the trial difference always fits WIDTH+1 signed bits
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, divisor_mag};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_next = trial_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit DIV unit (restoring, magnitudes + sign fix-up) for the multicycle MIPS datapath.
// Optional DIVU support is enabled by defining DIV_UNSIGNED_EN (adds the unsigned_op input).
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef DIV_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_r;
    div_state_t       state_next_s;
    logic             unsigned_s;
    logic             busy_s;
    logic             done_s;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic             unsigned_r;
    logic             zero_r;
    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH-1:0] dvs_mag_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic             sign_q_r;
    logic             sign_rem_r;
    logic [CNT_W-1:0] cnt_r;

`ifdef DIV_UNSIGNED_EN
    assign unsigned_s = unsigned_op;
`else
    assign unsigned_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero divisor still passes through SETUP so done lands one cycle after start
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SETUP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP: begin
                if (zero_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            RUN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so the registered copies line up with it
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_next_s)
            SETUP, RUN, FIX: busy_s = 1'b1;
            DONE:            done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Magnitudes are exact as unsigned WIDTH-bit values, including the most negative operand
    always_comb begin
        if (dividend_r[WIDTH-1] && !unsigned_r) begin
            dvd_mag_s = -dividend_r;
        end else begin
            dvd_mag_s = dividend_r;
        end
        if (divisor_r[WIDTH-1] && !unsigned_r) begin
            dvs_mag_s = -divisor_r;
        end else begin
            dvs_mag_s = divisor_r;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem_r),
        .quo         (quo_r),
        .divisor_mag (dvs_mag_r),
        .rem_next    (rem_next_s),
        .quo_next    (quo_next_s)
    );

    // Operand capture, iteration datapath and registered results
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            dividend_r <= {WIDTH{1'b0}};
            divisor_r  <= {WIDTH{1'b0}};
            unsigned_r <= 1'b0;
            zero_r     <= 1'b0;
            dvs_mag_r  <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        unsigned_r <= unsigned_s;
                        zero_r     <= (divisor == {WIDTH{1'b0}});
                        div_zero_r <= 1'b0;
                    end
                end
                SETUP: begin
                    quo_r      <= dvd_mag_s;
                    dvs_mag_r  <= dvs_mag_s;
                    rem_r      <= {WIDTH{1'b0}};
                    sign_q_r   <= !unsigned_r && (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]);
                    sign_rem_r <= !unsigned_r && dividend_r[WIDTH-1];
                    cnt_r      <= CNT_W'(WIDTH - 1);
                    if (zero_r) begin
                        div_zero_r <= 1'b1;
                    end
                end
                RUN: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                FIX: begin
                    lo_r <= sign_q_r ? -quo_r : quo_r;
                    hi_r <= sign_rem_r ? -rem_r : rem_r;
                end
                DONE: begin
                    zero_r <= 1'b0;
                end
                default: begin
                    zero_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi_out   = hi_r;
    assign lo_out   = lo_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands against a 64-bit arithmetic model.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        unsigned_op = 1'b0;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;
    logic        exp_dz = 1'b0;

    div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
`ifdef DIV_UNSIGNED_EN
        .unsigned_op (unsigned_op),
`endif
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Truncating signed division done in 64-bit arithmetic, so MIN/-1 needs no special case
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = 32'(sa / sb);
        r = 32'(sa % sb);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke_busy);
        int          last;
        logic [31:0] nq;
        logic [31:0] nr;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (b == 32'h0) begin
            last = 1;
            nq   = exp_lo;
            nr   = exp_hi;
        end else begin
            last = 34;
            ref_div(a, b, nq, nr);
        end
        for (int c = 0; c <= last; c++) begin
            @(negedge clock);
            chk("busy", {31'h0, busy}, {31'h0, c < last});
            chk("done", {31'h0, done}, {31'h0, c == last});
            if (c < last) begin
                chk("hi_hold", hi_out, exp_hi);
                chk("lo_hold", lo_out, exp_lo);
            end else begin
                chk("hi", hi_out, nr);
                chk("lo", lo_out, nq);
                chk("div_zero", {31'h0, div_zero}, {31'h0, b == 32'h0});
            end
            if (poke_busy && c == 4) begin
                start    = 1'b1;
                dividend = 32'd77;
                divisor  = 32'h0;
            end else if (poke_busy && c == 5) begin
                start = 1'b0;
            end
        end
        exp_hi = nr;
        exp_lo = nq;
        exp_dz = (b == 32'h0);
        @(negedge clock);
        chk("done_after", {31'h0, done}, 32'h0);
        chk("busy_after", {31'h0, busy}, 32'h0);
        chk("dz_sticky", {31'h0, div_zero}, {31'h0, exp_dz});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 32'h0;
        divisor  = 32'h0;
        #2;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_dz", {31'h0, div_zero}, 32'h0);
        chk("rst_hi", hi_out, 32'h0);
        chk("rst_lo", lo_out, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFFFF9C, 32'd7, 1'b0);
        run_op(32'd100, 32'hFFFFFFF9, 1'b0);
        run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0);
        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'd5, 32'h0, 1'b0);
        repeat (3) @(negedge clock);
        chk("dz_idle", {31'h0, div_zero}, 32'h1);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_op(32'h80000000, 32'h00000001, 1'b0);

        // Reset in the middle of a division abandons it with no done pulse
        @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (11) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_done", {31'h0, done}, 32'h0);
        chk("midrst_hi", hi_out, 32'h0);
        chk("midrst_lo", lo_out, 32'h0);
        @(negedge clock);
        reset  = 1'b1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        exp_dz = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            chk("no_done", {31'h0, done}, 32'h0);
        end
        run_op(32'd9, 32'd2, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) begin
                rb = $urandom_range(1, 15);
                if (i % 8 == 1) rb = -rb;
            end
            if (i % 7 == 3) rb = 32'h0;
            if (i == 10) ra = 32'h0;
            run_op(ra, rb, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
